// File: rtl/sched_pkg.sv
// Shared defaults and elaboration-time helpers for the warp issue scheduler.
package sched_pkg;

  localparam int unsigned DEF_NUM_WARPS  = 32'd4;
  localparam int unsigned DEF_ALU_LAT    = 32'd2;
  localparam int unsigned DEF_MEM_LAT    = 32'd4;
  localparam int unsigned DEF_GREEDY_MAX = 32'd8;

  // Index width for n items, never less than one bit.
  function automatic int unsigned sched_clog2(input int unsigned n);
    int unsigned w;
    w = 32'd1;
    while ((32'd1 << w) < n) begin
      w = w + 32'd1;
    end
    return w;
  endfunction

  // Number of cycles a MEM-hit writeback slot stays in flight beyond an ALU grant.
  function automatic int unsigned slot_depth(input int unsigned mem_lat, input int unsigned alu_lat);
    return (mem_lat > alu_lat) ? (mem_lat - alu_lat) : 32'd1;
  endfunction

endpackage

// File: rtl/sched_rr_arb.sv
// Rotating-priority arbiter with a combinational grant; greedy burst mode
// is built only when SCHED_GREEDY_EN is defined.
module sched_rr_arb
  import sched_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_NUM_WARPS,
  parameter int unsigned GREEDY_MAX = DEF_GREEDY_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] grant_o
);

  localparam int unsigned IW    = sched_clog2(WIDTH);
  localparam int unsigned EXT_W = IW + 32'd1;

  if (GREEDY_MAX < 32'd1) begin : g_greedy_check
    $error("sched_rr_arb: GREEDY_MAX must be at least 1");
  end

  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [EXT_W-1:0] idx_ext_s;
  logic [IW-1:0]    win_idx_s;
  logic             win_vld_s;
  logic [IW-1:0]    nxt_idx_s;
  logic [WIDTH-1:0] one_s;

  assign one_s = {{(WIDTH-1){1'b0}}, 1'b1};

  // Upward search from the pointer, wrapping at WIDTH; first hit wins.
  always_comb begin
    win_vld_s = 1'b0;
    win_idx_s = '0;
    idx_ext_s = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      idx_ext_s = {1'b0, ptr_q} + EXT_W'(k);
      idx_ext_s = (idx_ext_s >= EXT_W'(WIDTH)) ? (idx_ext_s - EXT_W'(WIDTH)) : idx_ext_s;
      if (!win_vld_s && req_i[idx_ext_s[IW-1:0]]) begin
        win_vld_s = 1'b1;
        win_idx_s = idx_ext_s[IW-1:0];
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  assign nxt_idx_s = (win_idx_s == IW'(WIDTH - 32'd1)) ? '0 : (win_idx_s + IW'(1));
  assign grant_o   = win_vld_s ? (one_s << win_idx_s) : '0;

`ifdef SCHED_GREEDY_EN
  localparam int unsigned CW = sched_clog2(GREEDY_MAX + 32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc_s;

  // Stay on the granted warp until its burst budget is spent.
  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    cnt_inc_s = (win_idx_s == ptr_q) ? (cnt_q + CW'(1)) : CW'(1);
    if (win_vld_s) begin
      if (cnt_inc_s >= CW'(GREEDY_MAX)) begin
        ptr_d = nxt_idx_s;
        cnt_d = '0;
      end else begin
        ptr_d = win_idx_s;
        cnt_d = cnt_inc_s;
      end
    end else begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
    end
  end

  // Burst counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Plain rotation: move past the winner, hold when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (win_vld_s) begin
      ptr_d = nxt_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end
`endif

  // Priority pointer state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/warp_issue_sched.sv
// Dual ALU/MEM warp issue scheduler with writeback-port conflict masking.
// Build option: SCHED_GREEDY_EN selects greedy burst arbitration.
module warp_issue_sched
  import sched_pkg::*;
#(
  parameter int unsigned NUM_WARPS  = DEF_NUM_WARPS,
  parameter int unsigned ALU_LAT    = DEF_ALU_LAT,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned GREEDY_MAX = DEF_GREEDY_MAX
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WARPS-1:0] ALU_Req_OC_Sched,
  input  logic [NUM_WARPS-1:0] ALU_RegWrite_OC_Sched,
  input  logic [NUM_WARPS-1:0] MEM_Req_OC_Sched,
  input  logic [NUM_WARPS-1:0] MEM_RegWrite_OC_Sched,
  input  logic                 MEM_WbResv_Sched,
  output logic [NUM_WARPS-1:0] ALU_Grt_Sched_OC,
  output logic [NUM_WARPS-1:0] MEM_Grt_Sched_OC,
  output logic                 WbConflict_Sched
);

  localparam int unsigned D = slot_depth(MEM_LAT, ALU_LAT);

  if (MEM_LAT <= ALU_LAT) begin : g_lat_check
    $error("warp_issue_sched: MEM_LAT must exceed ALU_LAT");
  end
  if ((NUM_WARPS < 32'd2) || (NUM_WARPS > 32'd32)) begin : g_warp_check
    $error("warp_issue_sched: NUM_WARPS must be within 2..32");
  end

  logic [D-1:0]         slot_q;
  logic [D-1:0]         slot_d;
  logic [NUM_WARPS-1:0] alu_req_s;
  logic [NUM_WARPS-1:0] mem_req_s;
  logic [NUM_WARPS-1:0] alu_mask_s;
  logic [NUM_WARPS-1:0] alu_elig_s;
  logic [NUM_WARPS-1:0] alu_grt_s;
  logic [NUM_WARPS-1:0] mem_grt_s;
  logic                 conflict_s;
  logic                 slot_ld_s;

  // Requests are ignored while reset is held so no grant can escape.
  assign alu_req_s = ALU_Req_OC_Sched & {NUM_WARPS{rst}};
  assign mem_req_s = MEM_Req_OC_Sched & {NUM_WARPS{rst}};

  // A MEM hit granted D cycles ago, or a miss reservation, owns the port
  // in the cycle an ALU grant issued now would write back.
  assign conflict_s = slot_q[D-1] | MEM_WbResv_Sched;

  // Only register-writing ALU requests collide with the reserved slot.
  always_comb begin
    alu_mask_s = '0;
    if (conflict_s) begin
      alu_mask_s = ALU_RegWrite_OC_Sched;
    end else begin
      alu_mask_s = '0;
    end
  end

  assign alu_elig_s = alu_req_s & ~alu_mask_s;

  sched_rr_arb #(
    .WIDTH      (NUM_WARPS),
    .GREEDY_MAX (GREEDY_MAX)
  ) u_alu_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (alu_elig_s),
    .grant_o (alu_grt_s)
  );

  sched_rr_arb #(
    .WIDTH      (NUM_WARPS),
    .GREEDY_MAX (GREEDY_MAX)
  ) u_mem_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   (mem_req_s),
    .grant_o (mem_grt_s)
  );

  assign slot_ld_s = |(mem_grt_s & MEM_RegWrite_OC_Sched);

  // Slot pipeline: bit 0 takes the new reservation, the rest shift up.
  always_comb begin
    slot_d    = '0;
    slot_d[0] = slot_ld_s;
    for (int unsigned i = 1; i < D; i++) begin
      slot_d[i] = slot_q[i-1];
    end
  end

  // Reservation shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign ALU_Grt_Sched_OC = alu_grt_s;
  assign MEM_Grt_Sched_OC = mem_grt_s;
  assign WbConflict_Sched = conflict_s & (|(alu_req_s & ALU_RegWrite_OC_Sched));

endmodule
